// File: rtl/ysyx_22040365_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier and restoring divider.
// Define YSYX_22040365_MDU_RADIX4_EN to retire two multiplier bits per cycle.
module ysyx_22040365_mdu #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam int         CNT_W    = $clog2(XLEN) + 1;
`ifdef YSYX_22040365_MDU_RADIX4_EN
    localparam int         STEP     = 2;
`else
    localparam int         STEP     = 1;
`endif

    state_t             state;
    logic [2:0]         fn_q;
    logic               word_q, sa_q, sb_q;
    logic [CNT_W-1:0]   cnt;
    logic [2*XLEN-1:0]  acc, mcand;
    logic [XLEN-1:0]    mplier, rem, quo, dvsr;

    // W results keep only the low word, sign-extended (also for the unsigned W ops).
    function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] raw, input logic word);
        return word ? XLEN'($signed(raw[31:0])) : raw;
    endfunction

    logic [2:0]         fn;
    logic               acc_word, illegal, sgn_a, sgn_b, sa, sb, spec_hit;
    logic [XLEN-1:0]    a_ext, b_ext, a_mag, b_mag, min_neg, spec_raw;
    logic [CNT_W-1:0]   n_full, cnt_init;

    always_comb begin
        // NOTE: every signal gets a value on every path, otherwise a latch is inferred.
        fn       = in_op[2:0];
        acc_word = in_op[3];
        sgn_a    = (fn == F_MULH) || (fn == F_MULHSU) || (fn == F_DIV) || (fn == F_REM);
        sgn_b    = (fn == F_MULH) || (fn == F_DIV) || (fn == F_REM);
        illegal  = acc_word && ((XLEN < 64) || (!fn[2] && fn != F_MUL));
        a_ext    = !acc_word ? in_a : sgn_a ? XLEN'($signed(in_a[31:0])) : XLEN'(in_a[31:0]);
        b_ext    = !acc_word ? in_b : sgn_b ? XLEN'($signed(in_b[31:0])) : XLEN'(in_b[31:0]);
        sa       = sgn_a & a_ext[XLEN-1];
        sb       = sgn_b & b_ext[XLEN-1];
        a_mag    = sa ? -a_ext : a_ext;
        b_mag    = sb ? -b_ext : b_ext;
        min_neg  = acc_word ? ({XLEN{1'b1}} << 31) : ({XLEN{1'b1}} << (XLEN - 1));
        n_full   = acc_word ? CNT_W'(32) : CNT_W'(XLEN);
        cnt_init = fn[2] ? n_full : (n_full >> (STEP - 1));
        spec_hit = 1'b1;
        spec_raw = '0;
        if (illegal)
            spec_raw = '0;
        else if (fn[2] && b_ext == '0)
            spec_raw = fn[1] ? a_ext : '1;
        else if (fn[2] && !fn[0] && a_ext == min_neg && b_ext == '1)
            spec_raw = fn[1] ? '0 : a_ext;
        else
            spec_hit = 1'b0;
    end

    logic [2*XLEN-1:0]  pp, acc_n, prod;
    logic [XLEN:0]      trial;
    logic [XLEN-1:0]    rem_n, quo_n, q_fix, r_fix, res_raw;

    always_comb begin
`ifdef YSYX_22040365_MDU_RADIX4_EN
        case (mplier[1:0])
            2'd0:    pp = '0;
            2'd1:    pp = mcand;
            2'd2:    pp = mcand << 1;
            default: pp = mcand + (mcand << 1);
        endcase
`else
        pp = mplier[0] ? mcand : '0;
`endif
        acc_n = acc + pp;
        prod  = (sa_q ^ sb_q) ? -acc_n : acc_n;
        // Restoring step: a negative trial difference leaves the shifted remainder untouched.
        trial = {rem, quo[XLEN-1]} - {1'b0, dvsr};
        rem_n = trial[XLEN] ? {rem[XLEN-2:0], quo[XLEN-1]} : trial[XLEN-1:0];
        quo_n = {quo[XLEN-2:0], ~trial[XLEN]};
        q_fix = (sa_q ^ sb_q) ? -quo_n : quo_n;
        r_fix = sa_q ? -rem_n : rem_n;
        if (fn_q[2])
            res_raw = fn_q[1] ? r_fix : q_fix;
        else
            res_raw = (fn_q == F_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            busy       <= 1'b0;
            fn_q       <= '0;
            word_q     <= 1'b0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            rem        <= '0;
            quo        <= '0;
            dvsr       <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    fn_q     <= fn;
                    word_q   <= acc_word;
                    sa_q     <= sa;
                    sb_q     <= sb;
                    out_tag  <= in_tag;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    cnt      <= cnt_init;
                    acc      <= '0;
                    mcand    <= {{XLEN{1'b0}}, a_mag};
                    mplier   <= b_mag;
                    rem      <= '0;
                    // A W dividend sits in the top word so its MSB is shifted out first.
                    quo      <= acc_word ? (a_mag << (XLEN - 32)) : a_mag;
                    dvsr     <= b_mag;
                    if (spec_hit) begin
                        out_result <= fin(spec_raw, acc_word);
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_n;
                    mcand  <= mcand << STEP;
                    mplier <= mplier >> STEP;
                    rem    <= rem_n;
                    quo    <= quo_n;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        out_result <= fin(res_raw, word_q);
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22040365_mdu.sv
// Scoreboard bench for ysyx_22040365_mdu: directed RV64M cases, random ops against
// an arithmetic reference model, backpressure, flush and reset checks.
module tb_ysyx_22040365_mdu;
`ifdef YSYX_22040365_MDU_RADIX4_EN
    localparam int MUL_STEP = 2;
`else
    localparam int MUL_STEP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [3:0]  in_op;
    logic [63:0] in_a, in_b, out_result;
    logic [4:0]  in_tag, out_tag;

    ysyx_22040365_mdu #(.XLEN(64), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] result;
        logic [4:0]  tag;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_miss = 0;
    int   hold_req = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic is_special(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        if (op[3] && op[2:0] != 3'd0 && !op[2]) return 1'b1;
        if (!op[2]) return 1'b0;
        if (op[3] ? (b[31:0] == 32'd0) : (b == 64'd0)) return 1'b1;
        if (op[0]) return 1'b0;
        if (op[3]) return a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
        return a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        int n = op[3] ? 32 : 64;
        if (is_special(op, a, b)) return 1;
        if (!op[2]) return n / MUL_STEP + 1;
        return n + 1;
    endfunction

    function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] pa, pb;
        logic [127:0]        pu;
        logic signed [63:0]  sa, sb;
        logic signed [31:0]  wa, wb;
        logic [31:0]         r32;
        logic                ovf;
        logic [63:0]         r;
        sa = a; sb = b; wa = a[31:0]; wb = b[31:0];
        r = '0; r32 = '0; pu = '0;
        if (!op[3]) begin
            ovf = (a == 64'h8000_0000_0000_0000) && (b == '1);
            case (op[2:0])
                3'd0: r = a * b;
                3'd1: begin pa = sa; pb = sb; pu = pa * pb; r = pu[127:64]; end
                3'd2: begin pa = sa; pb = {64'd0, b}; pu = pa * pb; r = pu[127:64]; end
                3'd3: begin pu = {64'd0, a} * {64'd0, b}; r = pu[127:64]; end
                3'd4: if (b == 0) r = '1; else if (ovf) r = a; else r = sa / sb;
                3'd5: if (b == 0) r = '1; else r = a / b;
                3'd6: if (b == 0) r = a; else if (ovf) r = '0; else r = sa % sb;
                default: if (b == 0) r = a; else r = a % b;
            endcase
        end else begin
            ovf = (a[31:0] == 32'h8000_0000) && (b[31:0] == '1);
            case (op[2:0])
                3'd0: r32 = a[31:0] * b[31:0];
                3'd4: if (wb == 0) r32 = '1; else if (ovf) r32 = wa; else r32 = wa / wb;
                3'd5: if (wb == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
                3'd6: if (wb == 0) r32 = wa; else if (ovf) r32 = '0; else r32 = wa % wb;
                3'd7: if (wb == 0) r32 = wa; else r32 = a[31:0] % b[31:0];
                default: r32 = '0;
            endcase
            r = {{32{r32[31]}}, r32};
        end
        return r;
    endfunction

    // Drive one request, wait for acceptance, and record what the result must be.
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag, input logic [63:0] exp);
        int waitc = 0;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        while (!in_ready) begin
            @(negedge clk);
            if (++waitc > 1000) begin
                check("accept_timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back('{exp, tag, ref_lat(op, a, b), cyc});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic issue_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
        issue(op, a, b, tag, ref_model(op, a, b));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 || !in_ready || out_valid) begin
            @(negedge clk);
            if (++n > 2000) begin
                check("drain_timeout", 64'(exp_q.size()), 64'd0);
                return;
            end
        end
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'(32'h8000_0000);
            4: return 64'($urandom_range(0, 20));
            5: return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: pops the scoreboard on each new result and applies random backpressure.
    initial begin : monitor
        exp_t cur;
        logic have = 1'b0;
        logic handoff = 1'b0;
        int   hold_left = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have = 1'b0; handoff = 1'b0; hold_left = 0;
                continue;
            end
            if (handoff) begin
                check("in_ready_after_handoff", 64'(in_ready), 64'd1);
                handoff = 1'b0;
            end
            if (out_valid) begin
                if (!have) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out_valid", 64'(out_valid), 64'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        have = 1'b1;
                        check("latency", 64'(cyc - cur.acc_cyc), 64'(cur.lat));
                        check("result", out_result, cur.result);
                        check("tag", 64'(out_tag), 64'(cur.tag));
                        hold_left = hold_req;
                        hold_req = 0;
                    end
                end else begin
                    check("held_result", out_result, cur.result);
                    check("held_tag", 64'(out_tag), 64'(cur.tag));
                    check("held_in_ready", 64'(in_ready), 64'd0);
                    check("held_busy", 64'(busy), 64'd1);
                end
                if (hold_left > 0) begin
                    out_ready = 1'b0;
                    hold_left--;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                if (out_ready && have) begin
                    have = 1'b0;
                    handoff = 1'b1;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        issue(4'b0000, 64'd7, -64'd3, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB);
        issue(4'b0011, '1, 64'd2, 5'd2, 64'd1);
        issue(4'b0001, '1, '1, 5'd3, 64'd0);
        issue(4'b0100, -64'd20, 64'd3, 5'd4, -64'd6);
        issue(4'b0110, -64'd20, 64'd3, 5'd5, -64'd2);
        issue(4'b0101, 64'h8000_0000_0000_0000, 64'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(4'b0110, 64'd5, 64'd0, 5'd7, 64'd5);
        issue(4'b1100, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF, 5'd8, 64'hFFFF_FFFF_8000_0000);
        issue(4'b1111, 64'hFFFF_FFFF, 64'h10, 5'd9, 64'hF);
        issue(4'b1000, 64'h7FFF_FFFF, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(4'b1001, 64'd3, 64'd4, 5'd11, 64'd0);

        // Backpressure: hold the result for 10 cycles.
        wait_idle();
        hold_req = 10;
        issue(4'b0000, 64'd3, 64'd5, 5'h1A, 64'd15);

        // Flush in the middle of a divide, then a clean request.
        wait_idle();
        issue(4'b0100, 64'd100, 64'd7, 5'd12, 64'd14);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        issue(4'b0101, 64'd100, 64'd7, 5'd13, 64'd14);

        // Flush wins over a simultaneous request.
        wait_idle();
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; in_op = 4'b0000; in_a = 64'd2; in_b = 64'd2; in_tag = 5'd14;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_vs_valid_busy", 64'(busy), 64'd0);
        check("flush_vs_valid_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 150; i++)
            issue_model(4'($urandom_range(0, 15)), pick(), pick(), 5'($urandom_range(0, 31)));

        // Reset mid-divide discards the operation.
        wait_idle();
        issue(4'b0100, -64'd20, 64'd3, 5'd15, -64'd6);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_result", out_result, 64'd0);
        check("midrst_out_tag", 64'(out_tag), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        issue(4'b0111, 64'd17, 64'd5, 5'd16, 64'd2);

        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

    initial begin : watchdog
        #600000;
        check("watchdog_timeout", 64'd1, 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end
endmodule

// File: doc/ysyx_22040365_mdu.md
Name: ysyx_22040365_mdu

Overview:
- Iterative RV64M multiply/divide unit; parametrised, multi-cycle successor to the single-cycle EX stage.
- Sits beside the ALU in EX. Receives rs1/rs2 operands and a funct3-style opcode under a valid/ready handshake, and returns the rd write value under a second valid/ready handshake.
- Supports full-width and word (W) variants, a flush abort, and the RISC-V divide special cases.

Parameters:
- XLEN, 64, operand/result width; legal values 32 or 64. W ops are only legal when XLEN=64.
- TAG_W, 5, width of the pass-through tag (rd address).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_op  in  4  [3]=word op; [2:0]: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_a  in  XLEN  rs1 value.
- in_b  in  XLEN  rs2 value.
- in_tag  in  TAG_W  rd address, returned unchanged.
- flush  in  1  abort any in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  XLEN  rd write data.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; in_ready=1, out_valid=0, out_result=0, out_tag=0, busy=0. Iteration counter and datapath registers are cleared. Reset takes effect mid-operation and discards the operation.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid=1. On accept, latch the opcode and tag.
  - For W ops, take the low 32 bits of each operand: sign-extend for signed ops, zero-extend for unsigned ops.
  - Convert signed operands to magnitudes and record the result sign.
  - Iteration count N = 32 for W ops, else XLEN.
  - Next state is CALC, except for the special cases below.
- Special cases (accepting cycle -> DONE; out_valid on the next cycle):
  - Divisor zero: DIV/DIVU quotient = all ones; REM/REMU remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1): DIV quotient = dividend; REM = 0.
  - Illegal op (W with funct 001-011): result 0.
- CALC:
  - One iteration per cycle.
  - Multiply: shift-add, 2N-bit product register.
  - Divide: restoring, N-bit remainder and quotient.
  - The counter decrements; when it reaches 0, apply sign correction and move to DONE.
  - Sign correction: quotient sign = sa^sb; remainder sign = sign of dividend.
  - MUL returns the low N bits of the product; MULH* return the high N bits.
  - in_ready=0.
- DONE:
  - out_valid=1; out_result and out_tag are held stable until out_ready=1.
  - out_valid && out_ready -> IDLE.
  - No new request is accepted in the same cycle; in_ready rises the cycle after the handoff.
- W results: the 32-bit result is sign-extended to XLEN, including for DIVUW and REMUW.
- Latency, accept edge to out_valid: N+1 cycles for the normal path; 1 cycle for special cases.
- flush=1:
  - Forces IDLE on the next edge from any state and drops a pending DONE result.
  - When flush and in_valid are both high in IDLE, flush wins and nothing is accepted.
- Backpressure: out_ready=0 holds DONE indefinitely; busy stays high.
- rst and flush asserted together: rst takes priority; the behaviour is identical.

Optional Feature:
- Macro YSYX_22040365_MDU_RADIX4_EN.
- When defined:
  - The multiplier retires 2 multiplier bits per cycle using radix-4 add of 0/1/2/3 x multiplicand.
  - Multiply iteration count = N/2, so multiply latency = N/2+1.
  - Divide is unchanged.
- When undefined: radix-2 multiplier, latency N+1. Results are bit-identical either way.

Test Plan:
- XLEN=64, MUL a=7, b=-3 -> out_result=0xFFFFFFFFFFFFFFEB, out_valid exactly 65 cycles after accept (33 with RADIX4).
- MULHU a=0xFFFFFFFFFFFFFFFF, b=2 -> 0x0000000000000001; MULH a=-1, b=-1 -> 0.
- DIV a=-20, b=3 -> -6; REM same operands -> -2; DIVU a=0x80000000_00000000, b=0 -> 0xFFFFFFFFFFFFFFFF in 1 cycle; REM a=5, b=0 -> 5.
- DIVW a=0x00000000_80000000, b=0xFFFFFFFF -> 0xFFFFFFFF80000000 (overflow, 1 cycle); REMUW a=0xFFFFFFFF, b=0x10 -> 0xF; MULW 0x7FFFFFFF x 2 -> 0xFFFFFFFFFFFFFFFE.
- Backpressure/handshake: hold out_ready=0 for 10 cycles after out_valid -> result and tag (e.g. 0x1A) stable, in_ready=0; release -> in_ready=1 the following cycle.
- Flush at CALC cycle 20 -> out_valid never asserts for that op; next request accepted cleanly. Assert rst mid-DIV -> all outputs return to reset values the next cycle.
